sha3_job_loader: RTL and testbench



---
 rtl/sha3_scanner_pkg.sv | 24 ++
 rtl/sha3_job_loader.sv | 108 ++++++++++
 tb/tb_sha3_job_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_scanner_pkg.sv
// Shared definitions for the SHA-3 scanner job path: job geometry, word order
// within a job, and the job loader state encoding.
package sha3_scanner_pkg;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        READY
    } loader_state_e;

    localparam int unsigned THR_LO_IDX = 0;
    localparam int unsigned THR_HI_IDX = 1;
    localparam int unsigned TPL_BASE   = 2;

    function automatic int unsigned tpl_words(input bit proper);
        return proper ? 20 : 24;
    endfunction

    // Two threshold words precede the template words.
    function automatic int unsigned job_words(input bit proper);
        return tpl_words(proper) + 2;
    endfunction

endpackage

// File: rtl/sha3_job_loader.sv
// Assembles scan jobs from a framed 32-bit stream into a shadow buffer and
// launches each one with a single start pulse once the scanner is idle.
module sha3_job_loader
    import sha3_scanner_pkg::*;
#(
    parameter bit PROPER = 1'b1,
    localparam int unsigned TPL_WORDS = tpl_words(PROPER),
    localparam int unsigned JOB_WORDS = job_words(PROPER)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [31:0]                 s_data,
    input  logic                        s_last,
    input  logic                        scan_awaiting,
    output logic                        start,
    output logic [63:0]                 threshold,
    output logic [TPL_WORDS-1:0][31:0]  blockTemplate,
    output logic                        job_pending,
    output logic                        frame_err,
    output logic [31:0]                 jobs_started
);

    localparam logic [4:0] LAST_IDX = 5'(JOB_WORDS - 1);

    loader_state_e               state;
    logic [4:0]                  word_idx;
    logic                        launch_pending;
    logic [JOB_WORDS-1:0][31:0]  shadow;
    logic                        busy;
    logic                        accept;

    // launch_pending bridges the cycle before the scanner raises its awaiting flag.
    assign busy   = launch_pending | scan_awaiting;
    assign accept = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (accept && state == FILL) begin
            shadow[word_idx] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FILL;
            word_idx       <= '0;
            launch_pending <= 1'b0;
            s_ready        <= 1'b0;
            job_pending    <= 1'b0;
            start          <= 1'b0;
            threshold      <= '0;
            blockTemplate  <= '0;
            frame_err      <= 1'b0;
            jobs_started   <= '0;
        end else begin
            start   <= 1'b0;
            s_ready <= (state != READY);
            if (scan_awaiting) begin
                launch_pending <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (accept) begin
                        if (word_idx == LAST_IDX) begin
                            word_idx <= '0;
                            if (s_last) begin
                                state       <= READY;
                                s_ready     <= 1'b0;
                                job_pending <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= DRAIN;
                            end
                        end else if (s_last) begin
                            frame_err <= 1'b1;
                            word_idx  <= '0;
                        end else begin
                            word_idx <= word_idx + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state    <= FILL;
                        word_idx <= '0;
                    end
                end
                READY: begin
                    if (!busy) begin
                        threshold      <= {shadow[THR_HI_IDX], shadow[THR_LO_IDX]};
                        blockTemplate  <= shadow[JOB_WORDS-1:TPL_BASE];
                        start          <= 1'b1;
                        jobs_started   <= jobs_started + 32'd1;
                        launch_pending <= 1'b1;
                        job_pending    <= 1'b0;
                        s_ready        <= 1'b1;
                        state          <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_job_loader.sv
// Directed bench for sha3_job_loader: one instance per job format sharing
// clock, reset and stream data, with a simple scanner awaiting model.
module tb_sha3_job_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        vld = 1'b0;
    logic [31:0] data = '0;
    logic        last = 1'b0;
    logic        scan_awaiting = 1'b0;
    logic        sel = 1'b1;

    logic s_valid1, s_valid0;
    assign s_valid1 = vld & sel;
    assign s_valid0 = vld & ~sel;

    logic                s_ready1, start1, job_pending1, frame_err1;
    logic [63:0]         threshold1;
    logic [19:0][31:0]   tpl1;
    logic [31:0]         jobs_started1;

    logic                s_ready0, start0, job_pending0, frame_err0;
    logic [63:0]         threshold0;
    logic [23:0][31:0]   tpl0;
    logic [31:0]         jobs_started0;

    sha3_job_loader #(.PROPER(1'b1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_data(data), .s_last(last), .scan_awaiting(scan_awaiting),
        .start(start1), .threshold(threshold1), .blockTemplate(tpl1),
        .job_pending(job_pending1), .frame_err(frame_err1),
        .jobs_started(jobs_started1)
    );

    sha3_job_loader #(.PROPER(1'b0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0),
        .s_data(data), .s_last(last), .scan_awaiting(scan_awaiting),
        .start(start0), .threshold(threshold0), .blockTemplate(tpl0),
        .job_pending(job_pending0), .frame_err(frame_err0),
        .jobs_started(jobs_started0)
    );

    int   tests = 0;
    int   failed = 0;
    int   starts1 = 0;
    int   starts0 = 0;
    logic st_q = 1'b0;
    int   scan_cnt = 0;
    bit   auto_scan = 1'b0;

    // Start pulses are counted mid-cycle; the scanner model raises awaiting
    // in the cycle after start and drops it four cycles later.
    initial forever begin
        @(negedge clk);
        if (start1) starts1++;
        if (start0) starts0++;
        st_q = sel ? start1 : start0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (auto_scan) begin
            if (st_q) scan_cnt = 4;
            else if (scan_cnt > 0) scan_cnt--;
            scan_awaiting = (scan_cnt > 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Streams words 0..n-1; returns on the negedge after the last accepted word.
    task automatic send_job(input int n, input int last_at, input logic [31:0] lo,
                            input logic [31:0] hi, input logic [31:0] base, output int cycles);
        int   w;
        logic acc;
        w = 0;
        cycles = 0;
        while (w < n && cycles < 200) begin
            @(negedge clk);
            vld  = 1'b1;
            data = (w == 0) ? lo : (w == 1) ? hi : base + 32'(w - 2);
            last = (w == last_at);
            acc  = sel ? s_ready1 : s_ready0;
            cycles++;
            @(posedge clk);
            if (acc) w++;
        end
        @(negedge clk);
        vld  = 1'b0;
        last = 1'b0;
        if (w < n) check("send_timeout", 64'(w), 64'(n));
    endtask

    typedef struct {
        int          n;
        int          last_at;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] base;
        int          exp_starts;
        logic        exp_ferr;
        logic [63:0] exp_thr;
        logic [31:0] exp_t0;
        logic [31:0] exp_t19;
        logic [31:0] exp_jobs;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        int s0;

        vecs[0] = '{22, 21, 32'h0000FFFF, 32'h00000000, 32'h1000, 1, 1'b0,
                    64'h00000000_0000FFFF, 32'h1000, 32'h1013, 32'd1};
        vecs[1] = '{11, 10, 32'h0000AAAA, 32'h0000BBBB, 32'h2000, 0, 1'b1,
                    64'h00000000_0000FFFF, 32'h1000, 32'h1013, 32'd1};
        vecs[2] = '{22, 21, 32'h11111111, 32'h22222222, 32'h3000, 1, 1'b1,
                    64'h22222222_11111111, 32'h3000, 32'h3013, 32'd2};
        vecs[3] = '{30, 29, 32'h00000005, 32'h00000006, 32'h4000, 0, 1'b1,
                    64'h22222222_11111111, 32'h3000, 32'h3013, 32'd2};
        vecs[4] = '{22, 21, 32'h00000077, 32'h00000088, 32'h5000, 1, 1'b1,
                    64'h00000088_00000077, 32'h5000, 32'h5013, 32'd3};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready1", 64'(s_ready1), 64'd0);
        check("rst_ready0", 64'(s_ready0), 64'd0);
        check("rst_start1", 64'(start1), 64'd0);
        check("rst_thr1", threshold1, 64'd0);
        check("rst_tpl1", 64'(|tpl1), 64'd0);
        check("rst_pend1", 64'(job_pending1), 64'd0);
        check("rst_ferr1", 64'(frame_err1), 64'd0);
        check("rst_jobs1", 64'(jobs_started1), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(s_ready1), 64'd1);

        // Table-driven jobs on the 20-word format with the scanner model active
        auto_scan = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s0 = starts1;
            send_job(vecs[i].n, vecs[i].last_at, vecs[i].lo, vecs[i].hi, vecs[i].base, cyc);
            repeat (30) @(negedge clk);
            check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].n));
            check($sformatf("v%0d_starts", i), 64'(starts1 - s0), 64'(vecs[i].exp_starts));
            check($sformatf("v%0d_ferr", i), 64'(frame_err1), 64'(vecs[i].exp_ferr));
            check($sformatf("v%0d_thr", i), threshold1, vecs[i].exp_thr);
            check($sformatf("v%0d_tpl0", i), 64'(tpl1[0]), 64'(vecs[i].exp_t0));
            check($sformatf("v%0d_tpl19", i), 64'(tpl1[19]), 64'(vecs[i].exp_t19));
            check($sformatf("v%0d_jobs", i), 64'(jobs_started1), 64'(vecs[i].exp_jobs));
        end

        // Launch timing, then back-to-back under a running scan
        auto_scan = 1'b0;
        scan_awaiting = 1'b0;
        s0 = starts1;
        send_job(22, 21, 32'hC0, 32'hC1, 32'h6000, cyc);
        check("t_pend_n1", 64'(job_pending1), 64'd1);
        check("t_start_n1", 64'(start1), 64'd0);
        @(negedge clk);
        check("t_start_n2", 64'(start1), 64'd1);
        check("t_pend_n2", 64'(job_pending1), 64'd0);
        check("t_tpl_n2", 64'(tpl1[19]), 64'h6013);
        check("t_thr_n2", threshold1, 64'h000000C1_000000C0);
        @(negedge clk);
        scan_awaiting = 1'b1;
        send_job(22, 21, 32'hD0, 32'hD1, 32'h7000, cyc);
        repeat (3) @(negedge clk);
        check("b2b_pend", 64'(job_pending1), 64'd1);
        check("b2b_hold_tpl", 64'(tpl1[19]), 64'h6013);
        check("b2b_hold_thr", threshold1, 64'h000000C1_000000C0);
        check("b2b_starts", 64'(starts1 - s0), 64'd1);
        scan_awaiting = 1'b0;
        check("b2b_start_m", 64'(start1), 64'd0);
        @(negedge clk);
        check("b2b_start_m1", 64'(start1), 64'd1);
        check("b2b_tpl", 64'(tpl1[19]), 64'h7013);
        check("b2b_thr", threshold1, 64'h000000D1_000000D0);

        // Scanner slow to raise awaiting: the next job must wait regardless
        send_job(22, 21, 32'hE0, 32'hE1, 32'h8000, cyc);
        repeat (3) @(negedge clk);
        check("lag_starts", 64'(starts1 - s0), 64'd2);
        check("lag_pend", 64'(job_pending1), 64'd1);
        check("lag_hold_tpl", 64'(tpl1[19]), 64'h7013);
        scan_awaiting = 1'b1;
        @(negedge clk);
        @(negedge clk);
        scan_awaiting = 1'b0;
        check("lag_start_m", 64'(start1), 64'd0);
        @(negedge clk);
        check("lag_start_m1", 64'(start1), 64'd1);
        check("lag_tpl", 64'(tpl1[19]), 64'h8013);
        @(negedge clk);
        check("lag_starts_final", 64'(starts1 - s0), 64'd3);
        check("lag_jobs", 64'(jobs_started1), 64'd6);

        // 24-word format, reset mid-job, then a fresh job
        sel = 1'b0;
        scan_cnt = 0;
        auto_scan = 1'b1;
        s0 = starts0;
        send_job(26, 25, 32'hF0, 32'hF1, 32'h9000, cyc);
        repeat (20) @(negedge clk);
        check("p0_starts", 64'(starts0 - s0), 64'd1);
        check("p0_tpl23", 64'(tpl0[23]), 64'h9017);
        check("p0_tpl0", 64'(tpl0[0]), 64'h9000);
        check("p0_thr", threshold0, 64'h000000F1_000000F0);
        check("p0_jobs", 64'(jobs_started0), 64'd1);
        check("p0_ferr", 64'(frame_err0), 64'd0);
        send_job(7, 99, 32'h1, 32'h2, 32'hB000, cyc);
        rst = 1'b1;
        @(negedge clk);
        check("p0_rst_thr", threshold0, 64'd0);
        check("p0_rst_tpl", 64'(|tpl0), 64'd0);
        check("p0_rst_jobs", 64'(jobs_started0), 64'd0);
        check("p0_rst_pend", 64'(job_pending0), 64'd0);
        check("p0_rst_ready", 64'(s_ready0), 64'd0);
        check("p1_rst_jobs", 64'(jobs_started1), 64'd0);
        rst = 1'b0;
        s0 = starts0;
        send_job(26, 25, 32'h31, 32'h32, 32'hA000, cyc);
        repeat (20) @(negedge clk);
        check("p0b_starts", 64'(starts0 - s0), 64'd1);
        check("p0b_tpl23", 64'(tpl0[23]), 64'hA017);
        check("p0b_tpl2", 64'(tpl0[2]), 64'hA002);
        check("p0b_thr", threshold0, 64'h00000032_00000031);
        check("p0b_jobs", 64'(jobs_started0), 64'd1);
        check("p0b_ferr", 64'(frame_err0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
